imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Immediate field encoder: the inverse of the decode-stage immediate sign extension.
//  Accepts a full-width signed value plus an immediate type from the assembler/loader path.
//  Narrows the value to the raw instruction immediate field and range-checks it.
//  Results are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_WIDTH     36  width of the signed input value
//  SELECT_WIDTH   2   width of the immediate type selector
//  IMM_MAX_WIDTH  14  width of the raw immediate field (J-type size)
//  I_WIDTH        8   I-type immediate width
//  ERR_CNT_WIDTH  8   width of the saturating range-error counter
// PORTS
//  i_clk        in   1              clock, rising edge
//  i_rst        in   1              asynchronous active-high reset
//  i_valid      in   1              input value/select valid
//  o_ready      out  1              encoder can accept (FIFO not full)
//  i_value      in   DATA_WIDTH     signed value to encode
//  i_immSel     in   SELECT_WIDTH   00 R-type (none), 01 I-type, 10 J-type, 11 reserved
//  o_valid      out  1              head FIFO entry valid
//  i_ready      in   1              downstream accepts head entry
//  o_immRaw     out  IMM_MAX_WIDTH  encoded raw immediate field
//  o_immSel     out  SELECT_WIDTH   select carried with the entry
//  o_range_err  out  1              entry's value was not representable
//  i_clr_err    in   1              synchronous clear of the error counter
//  o_err_count  out  ERR_CNT_WIDTH  saturating count of accepted errored entries
// BEHAVIOUR
//  - Reset (async, i_rst=1): FIFO empty, o_valid=0, o_immRaw=0, o_immSel=0,
//    o_range_err=0, o_err_count=0. o_ready=1 once reset is released.
//  - Accept: input is accepted when i_valid && o_ready. Pop: head is removed when o_valid && i_ready.
//  - Encoding is combinational on accept and written into the FIFO in the same edge.
//  - Latency: a value accepted at edge N is visible on o_valid/o_immRaw after edge N; no bypass.
//  - Encoding rules:
//    - 00: o_immRaw = 0. err = (i_value != 0).
//    - 01: o_immRaw = {6'b0, i_value[7:0]}. err unless i_value[35:7] are all equal.
//    - 10: o_immRaw = i_value[13:0]. err unless i_value[35:13] are all equal.
//    - 11: o_immRaw = 0. err = 1.
//  - Errored entries are still enqueued (with o_range_err=1); they are never dropped.
//  - FIFO: 2 entries, count 0..2, read/write pointers wrap modulo 2. o_ready = (count != 2).
//    - Push and pop in the same cycle with count 1: count stays 1 and the new entry becomes head next cycle.
//    - Pop with count 0: impossible, since o_valid=0.
//    - Push with count 2: impossible, since o_ready=0.
//  - The head entry is held stable while o_valid && !i_ready.
//  - Error counter: +1 on each accepted errored entry; saturates at all-ones.
//    i_clr_err has priority: if clear and an errored accept occur in the same cycle, the counter becomes 0.
//  - Reset asserted mid-transfer discards all FIFO contents and the counter; no partial state survives.
// TESTING
//  - Reset: hold i_rst with i_valid=1 -> o_valid=0, o_ready=0/ignored, o_err_count=0.
//    After release, o_ready=1.
//  - I-type in range: sel=01, value=-5 (36'hFFFFFFFFB) -> next cycle o_immRaw=14'h00FB, o_range_err=0.
//  - Range errors: sel=01, value=128 -> o_range_err=1, o_err_count=1.
//    sel=10, value=-8193 -> err. sel=10, value=-8192 -> o_immRaw=14'h2000, no err.
//  - Backpressure: i_ready=0, push 3 values -> o_ready=0 after 2.
//    3rd value held until a pop; entries emerge in order, head stable while stalled.
//  - Simultaneous push/pop at count 1 over 10 cycles -> count stays 1, ordering preserved, no loss.
//  - Counter: 260 errored accepts (sel=11) -> o_err_count=255.
//    i_clr_err with an errored accept in the same cycle -> 0.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate field encoder: narrows a signed value to its raw instruction immediate,
// range-checks it, and queues the result in a 2-entry valid/ready FIFO.
module imm_encoder #(
  parameter int DATA_WIDTH    = 36,
  parameter int SELECT_WIDTH  = 2,
  parameter int IMM_MAX_WIDTH = 14,
  parameter int I_WIDTH       = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_value,
  input  logic [SELECT_WIDTH-1:0]  i_immSel,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [IMM_MAX_WIDTH-1:0] o_immRaw,
  output logic [SELECT_WIDTH-1:0]  o_immSel,
  output logic                     o_range_err,
  input  logic                     i_clr_err,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  typedef struct packed {
    logic [IMM_MAX_WIDTH-1:0] raw;
    logic [SELECT_WIDTH-1:0]  sel;
    logic                     err;
  } entry_t;

  entry_t                   r_mem [2];
  logic                     r_wptr;
  logic                     r_rptr;
  logic [1:0]               r_count;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  entry_t                          w_enc;
  logic                            w_push;
  logic                            w_pop;
  logic [DATA_WIDTH-I_WIDTH:0]     w_i_hi;
  logic [DATA_WIDTH-IMM_MAX_WIDTH:0] w_j_hi;

  // A value fits a field iff every bit from the field's sign bit upward agrees.
  assign w_i_hi = i_value[DATA_WIDTH-1:I_WIDTH-1];
  assign w_j_hi = i_value[DATA_WIDTH-1:IMM_MAX_WIDTH-1];

  always_comb begin
    w_enc     = '0;
    w_enc.sel = i_immSel;
    case (i_immSel)
      SELECT_WIDTH'(0): w_enc.err = |i_value;
      SELECT_WIDTH'(1): begin
        w_enc.raw = {{(IMM_MAX_WIDTH-I_WIDTH){1'b0}}, i_value[I_WIDTH-1:0]};
        w_enc.err = !((&w_i_hi) || !(|w_i_hi));
      end
      SELECT_WIDTH'(2): begin
        w_enc.raw = i_value[IMM_MAX_WIDTH-1:0];
        w_enc.err = !((&w_j_hi) || !(|w_j_hi));
      end
      default: w_enc.err = 1'b1;
    endcase
  end

  assign o_ready     = (r_count != 2'd2) && !i_rst;
  assign o_valid     = (r_count != 2'd0);
  assign w_push      = i_valid && o_ready;
  assign w_pop       = o_valid && i_ready;
  assign o_immRaw    = r_mem[r_rptr].raw;
  assign o_immSel    = r_mem[r_rptr].sel;
  assign o_range_err = r_mem[r_rptr].err;
  assign o_err_count = r_err_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_enc;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // Clear wins over a same-cycle errored accept.
      if (i_clr_err)
        r_err_cnt <= '0;
      else if (w_push && w_enc.err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, hand-written FIFO corner sequences,
// and randomized traffic scored against a queue-based model at every negedge.
module tb_imm_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_clr_err = 1'b0;
  logic [35:0] i_value = '0;
  logic [1:0]  i_immSel = '0;
  logic        o_ready, o_valid, o_range_err;
  logic [13:0] o_immRaw;
  logic [1:0]  o_immSel;
  logic [7:0]  o_err_count;

  imm_encoder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_value(i_value), .i_immSel(i_immSel), .o_valid(o_valid), .i_ready(i_ready),
    .o_immRaw(o_immRaw), .o_immSel(o_immSel), .o_range_err(o_range_err),
    .i_clr_err(i_clr_err), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [13:0] raw;
    logic [1:0]  sel;
    logic        err;
  } ent_t;

  typedef struct {
    logic [1:0]  sel;
    longint      val;
    logic [13:0] raw;
    logic        err;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  ent_t q[$];
  int   mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the numeric range of each field.
  function automatic ent_t ref_enc(input logic [1:0] sel, input longint v);
    ent_t e;
    e.sel = sel;
    case (sel)
      2'd0: begin e.raw = 14'd0; e.err = (v != 0); end
      2'd1: begin e.raw = 14'(v & 255);   e.err = (v < -128)  || (v > 127);  end
      2'd2: begin e.raw = 14'(v & 16383); e.err = (v < -8192) || (v > 8191); end
      default: begin e.raw = 14'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      bit   acc, pop;
      ent_t e;
      acc = i_valid && (q.size() < 2);
      pop = (q.size() > 0) && i_ready;
      e   = ref_enc(i_immSel, longint'($signed(i_value)));
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (i_clr_err) mcnt = 0;
      else if (acc && e.err && mcnt != 255) mcnt++;
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      if (!i_rst) chk("sb_ready", o_ready, q.size() != 2);
      chk("sb_valid", o_valid, q.size() != 0);
      chk("sb_errcnt", o_err_count, mcnt);
      if (q.size() != 0) begin
        chk("sb_raw", o_immRaw, q[0].raw);
        chk("sb_sel", o_immSel, q[0].sel);
        chk("sb_err", o_range_err, q[0].err);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drv(input bit v, input logic [1:0] s, input longint val);
    i_valid  = v;
    i_immSel = s;
    i_value  = val[35:0];
  endtask

  function automatic longint rnd_val();
    logic [35:0] r;
    r = 36'({$urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 600)) - 300;
      1: return longint'($urandom_range(0, 40000)) - 20000;
      2: return 0;
      default: return longint'($signed(r));
    endcase
  endfunction

  vec_t tv[12];
  int   exp_cnt;

  initial begin
    tv[0]  = '{2'd1, -5,    14'h00FB, 1'b0};
    tv[1]  = '{2'd1, 128,   14'h0080, 1'b1};
    tv[2]  = '{2'd1, 127,   14'h007F, 1'b0};
    tv[3]  = '{2'd1, -128,  14'h0080, 1'b0};
    tv[4]  = '{2'd1, -129,  14'h007F, 1'b1};
    tv[5]  = '{2'd2, -8193, 14'h1FFF, 1'b1};
    tv[6]  = '{2'd2, -8192, 14'h2000, 1'b0};
    tv[7]  = '{2'd2, 8191,  14'h1FFF, 1'b0};
    tv[8]  = '{2'd2, 8192,  14'h2000, 1'b1};
    tv[9]  = '{2'd0, 0,     14'h0000, 1'b0};
    tv[10] = '{2'd0, 1,     14'h0000, 1'b1};
    tv[11] = '{2'd3, 0,     14'h0000, 1'b1};

    // Reset held with a pending input: nothing may be accepted.
    chk_en = 1'b1;
    drv(1, 2'd1, 5);
    repeat (3) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_raw", o_immRaw, 0);
    chk("rst_sel", o_immSel, 0);
    chk("rst_err", o_range_err, 0);
    chk("rst_errcnt", o_err_count, 0);
    i_valid = 1'b0;
    i_rst   = 1'b0;
    #1 chk("rst_ready_after", o_ready, 1);
    tick();

    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drv(1, tv[i].sel, tv[i].val);
      i_ready = 1'b0;
      tick();
      i_valid = 1'b0;
      exp_cnt += int'(tv[i].err);
      chk("tv_valid", o_valid, 1);
      chk("tv_raw", o_immRaw, tv[i].raw);
      chk("tv_sel", o_immSel, tv[i].sel);
      chk("tv_err", o_range_err, tv[i].err);
      chk("tv_errcnt", o_err_count, exp_cnt);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end

    // Backpressure: third value waits until a slot frees.
    drv(1, 2'd1, 10); tick();
    drv(1, 2'd1, 20); tick();
    chk("bp_ready_full", o_ready, 0);
    drv(1, 2'd1, 30);
    repeat (3) begin
      tick();
      chk("bp_head_stable", o_immRaw, 10);
      chk("bp_ready_stall", o_ready, 0);
    end
    i_ready = 1'b1;
    tick();
    chk("bp_order_b", o_immRaw, 20);
    tick();
    i_valid = 1'b0;
    chk("bp_order_c", o_immRaw, 30);
    tick();
    chk("bp_drained", o_valid, 0);
    i_ready = 1'b0;

    // Push and pop together with one entry resident.
    drv(1, 2'd2, 100); tick();
    i_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drv(1, 2'd2, 100 + k);
      tick();
      chk("pp_ready", o_ready, 1);
      chk("pp_valid", o_valid, 1);
      chk("pp_head", o_immRaw, 100 + k);
    end
    i_valid = 1'b0;
    tick();
    chk("pp_drained", o_valid, 0);

    // Saturating counter, then clear racing an errored accept.
    drv(1, 2'd3, 0);
    repeat (260) tick();
    i_valid = 1'b0;
    chk("sat_cnt", o_err_count, 255);
    tick();
    drv(1, 2'd3, 0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    i_valid   = 1'b0;
    chk("clr_prio", o_err_count, 0);
    chk("clr_entry_err", o_range_err, 1);
    tick();
    i_ready = 1'b0;

    // Asynchronous reset with a full FIFO.
    drv(1, 2'd3, 5); tick();
    drv(1, 2'd2, 6); tick();
    i_valid = 1'b0;
    chk("mr_pre_cnt", o_err_count, 1);
    chk("mr_pre_full", o_ready, 0);
    i_rst = 1'b1;
    #1;
    chk("mr_valid", o_valid, 0);
    chk("mr_errcnt", o_err_count, 0);
    chk("mr_raw", o_immRaw, 0);
    tick();
    i_rst = 1'b0;
    tick();
    chk("mr_ready", o_ready, 1);

    repeat (400) begin
      i_valid   = ($urandom_range(0, 1) == 1);
      i_ready   = ($urandom_range(0, 3) != 0);
      i_clr_err = ($urandom_range(0, 31) == 0);
      i_immSel  = 2'($urandom_range(0, 3));
      i_value   = 36'(rnd_val());
      tick();
    end
    i_valid   = 1'b0;
    i_clr_err = 1'b0;
    i_ready   = 1'b1;
    repeat (3) tick();
    chk("final_drained", o_valid, 0);
    @(negedge i_clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
